systolic_result_drain: RTL and testbench
========================================

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the width of one result element.
REQ-002 The module SHALL have parameter M, default 3, giving the result matrix dimension (M x M); legal range 1..16.
REQ-003 The module SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The module SHALL have port capture, input, 1 bit: single-cycle request to snapshot result_in and stream it out; normally driven by the array's done.
REQ-006 The module SHALL have port result_in, input, DATA_WIDTH x [0:M-1][0:M-1]: parallel result matrix from the PE grid.
REQ-007 The module SHALL have port m_valid, output, 1 bit: output beat valid.
REQ-008 The module SHALL have port m_ready, input, 1 bit: downstream (host) ready.
REQ-009 The module SHALL have port m_data, output, DATA_WIDTH: current element.
REQ-010 The module SHALL have port m_last, output, 1 bit: end marker, see REQ-030.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a matrix is held or being streamed.
REQ-012 The module SHALL have port drained, output, 1 bit: one-cycle pulse after the final beat is accepted.
REQ-013 The module SHALL have port capture_err, output, 1 bit: one-cycle pulse when capture arrives outside IDLE.

Function
REQ-014 The module SHALL implement three states: IDLE, STREAM and DONE.
REQ-015 In IDLE, capture=1 SHALL copy all M*M elements of result_in into an internal snapshot bank, clear the row/column counters and enter STREAM on the same edge.
REQ-016 m_valid SHALL be high from the first cycle in STREAM, giving one cycle of latency from the capture edge to beat [0][0].
REQ-017 Beats SHALL be emitted in row-major order: [0][0], [0][1] .. [0][M-1], [1][0] .. [M-1][M-1]; total exactly M*M beats.
REQ-018 m_data SHALL equal snapshot[row][col]; the column counter and row counter are each $clog2(M)+1 bits wide.
REQ-019 A beat SHALL transfer only when m_valid=1 and m_ready=1; the counters advance by exactly one element per transfer.
REQ-020 While m_valid=1 and m_ready=0, m_data, m_last and m_valid SHALL hold stable.
REQ-021 With m_ready held at 1, throughput SHALL be one beat per cycle, with no bubbles between rows.
REQ-022 Column wrap: a transfer at col=M-1 SHALL set col to 0 and increment row.
REQ-023 A transfer of element [M-1][M-1] SHALL deassert m_valid on the same edge and enter DONE.
REQ-024 DONE SHALL last exactly one cycle, with drained=1, then return to IDLE.
REQ-025 busy SHALL be 1 in STREAM and DONE and 0 in IDLE.
REQ-026 capture in STREAM or DONE SHALL be ignored (the snapshot is unchanged) and SHALL pulse capture_err for one cycle.
REQ-027 Changes on result_in after the capture edge SHALL NOT affect streamed data.
REQ-028 When M=1, exactly one beat SHALL be emitted, with m_last=1.
REQ-029 m_valid SHALL never be asserted in IDLE or DONE.
REQ-030 m_last behaviour SHALL be as defined in REQ-034 and REQ-035.

Reset
REQ-031 While reset is asserted, the module SHALL force state=IDLE, row=0, col=0, m_valid=0, m_last=0, busy=0, drained=0 and capture_err=0; the snapshot bank SHALL clear to 0.
REQ-032 Reset asserted mid-STREAM SHALL drop m_valid immediately (asynchronously) and discard the held matrix; drained SHALL NOT pulse.
REQ-033 The first capture after reset release SHALL be accepted normally.

Configuration
REQ-034 With macro DRAIN_ROW_LAST_EN defined, m_last SHALL be 1 on every beat with col=M-1 (end of each row).
REQ-035 Without DRAIN_ROW_LAST_EN, m_last SHALL be 1 only on beat [M-1][M-1]; all other behaviour is identical.

Verification
REQ-036 The bench SHALL cover: M=3, result_in=1..9 row-major, capture at cycle 0, m_ready=1 -> m_data 1..9 on cycles 1..9; m_last on 9 (and also on 3 and 6 with the macro); drained at cycle 10; busy cycles 1..10.
REQ-037 The bench SHALL cover: same stimulus, m_ready toggled 1,0,0,1,... -> the 9 values arrive in order with none dropped or duplicated, and m_data is stable during stalls.
REQ-038 The bench SHALL cover: capture at cycle 4 during STREAM, with result_in changed to all 0xFF -> capture_err pulses once and the stream still delivers 1..9.
REQ-039 The bench SHALL cover: reset asserted after beat 5 -> m_valid=0 immediately, no drained pulse; a fresh capture with 10..18 then streams 10..18 from [0][0].
REQ-040 The bench SHALL cover: M=1, result_in=0xDEADBEEF -> one beat with m_last=1, then drained on the next cycle.
REQ-041 The bench SHALL cover: capture asserted in the DONE cycle -> capture_err pulses; capture on the following IDLE cycle is accepted.

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Snapshots the M x M result matrix of a systolic PE grid on a single-cycle
//   capture request and streams it out row-major over a valid/ready
//   handshake, one element per beat.
//
//   Optional feature macro: DRAIN_ROW_LAST_EN
//     defined   -> m_last marks the end of every row (col == M-1)
//     undefined -> m_last marks only the final element [M-1][M-1]
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   capture      snapshot request (accepted only in IDLE)
//   result_in    parallel result matrix [0:M-1][0:M-1], DATA_WIDTH each
//   m_valid      output beat valid (high throughout STREAM)
//   m_ready      downstream ready
//   m_data       current element snapshot[row][col]
//   m_last       end marker (see macro above)
//   busy         high in STREAM and DONE
//   drained      one-cycle pulse in DONE, after the final beat is accepted
//   capture_err  one-cycle pulse after a capture request arrives outside IDLE
module systolic_result_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  capture,
   input  logic [DATA_WIDTH-1:0] result_in [0:M-1][0:M-1],
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  drained,
   output logic                  capture_err
);

   localparam int CW = $clog2(M) + 1;
   // Index width the snapshot array expects; the counters carry a spare MSB.
   localparam int IW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic                  capture_err_q, capture_err_d;
   logic [DATA_WIDTH-1:0] snap_q [0:M-1][0:M-1];
   logic [DATA_WIDTH-1:0] snap_d [0:M-1][0:M-1];

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      snap_d        = snap_q;
      capture_err_d = capture && (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (capture) begin
               snap_d  = result_in;
               row_d   = '0;
               col_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            // m_valid is implied by STREAM, so m_ready alone marks a transfer.
            if (m_ready) begin
               if (col_q == LAST_IDX) begin
                  col_d = '0;
                  if (row_q == LAST_IDX) begin
                     row_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         row_q         <= '0;
         col_q         <= '0;
         capture_err_q <= 1'b0;
         for (int unsigned r = 0; r < M; r++) begin
            for (int unsigned c = 0; c < M; c++) begin
               snap_q[r][c] <= '0;
            end
         end
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         capture_err_q <= capture_err_d;
         snap_q        <= snap_d;
      end
   end

   // Outputs decode straight from state so reset drops them asynchronously.
   assign m_valid     = (state_q == S_STREAM);
   assign busy        = (state_q != S_IDLE);
   assign drained     = (state_q == S_DONE);
   assign capture_err = capture_err_q;
   assign m_data      = snap_q[row_q[IW-1:0]][col_q[IW-1:0]];

`ifdef DRAIN_ROW_LAST_EN
   assign m_last = m_valid && (col_q == LAST_IDX);
`else
   assign m_last = m_valid && (col_q == LAST_IDX) && (row_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain
//   Two instances (M=3 and M=1, DATA_WIDTH=32) driven with directed and
//   randomized stimulus; a beat-index reference model predicts every output
//   each cycle, and collected beat sequences are compared per scenario.
module tb_systolic_result_drain;

   logic        clk;
   logic        reset;

   logic        cap3, rdy3, v3, l3, b3, dr3, e3;
   logic [31:0] d3;
   logic [31:0] res3 [0:2][0:2];

   logic        cap1, rdy1, v1, l1, b1, dr1, e1;
   logic [31:0] d1;
   logic [31:0] res1 [0:0][0:0];

   systolic_result_drain #(.DATA_WIDTH(32), .M(3)) u_dut3 (
      .clk(clk), .reset(reset), .capture(cap3), .result_in(res3),
      .m_valid(v3), .m_ready(rdy3), .m_data(d3), .m_last(l3),
      .busy(b3), .drained(dr3), .capture_err(e3)
   );

   systolic_result_drain #(.DATA_WIDTH(32), .M(1)) u_dut1 (
      .clk(clk), .reset(reset), .capture(cap1), .result_in(res1),
      .m_valid(v1), .m_ready(rdy1), .m_data(d1), .m_last(l1),
      .busy(b1), .drained(dr1), .capture_err(e1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: phase 0 idle, 1 streaming (k = next beat index), 2 done.
   int          mode [2];
   int          k    [2];
   bit          err_m[2];
   logic [31:0] msnap[2][9];

   // Per-scenario observations
   int          cyc;
   int          c0;
   logic [31:0] got0[$];
   logic [31:0] got1[$];
   int          last_at0[$];
   int          cnt_dr [2];
   int          cnt_err[2];
   int          cnt_busy0;
   int          first_v [2];
   int          first_dr[2];

   task automatic clear_stats();
      got0.delete(); got1.delete(); last_at0.delete();
      for (int d = 0; d < 2; d++) begin
         cnt_dr[d] = 0; cnt_err[d] = 0; first_v[d] = -1; first_dr[d] = -1;
      end
      cnt_busy0 = 0;
      c0 = cyc;
   endtask

   task automatic sample_check(input int d);
      logic v, l, b, dr, e, rd;
      logic [31:0] dat;
      int n;
      bit exp_last;
      if (d == 0) begin
         v = v3; l = l3; b = b3; dr = dr3; e = e3; rd = rdy3; dat = d3; n = 3;
      end else begin
         v = v1; l = l1; b = b1; dr = dr1; e = e1; rd = rdy1; dat = d1; n = 1;
      end
      chk($sformatf("d%0d_valid", d), v, mode[d] == 1);
      chk($sformatf("d%0d_busy", d), b, mode[d] != 0);
      chk($sformatf("d%0d_drained", d), dr, mode[d] == 2);
      chk($sformatf("d%0d_cap_err", d), e, err_m[d]);
      if (mode[d] == 1) begin
`ifdef DRAIN_ROW_LAST_EN
         exp_last = (k[d] % n) == n - 1;
`else
         exp_last = k[d] == n * n - 1;
`endif
         chk($sformatf("d%0d_data_k%0d", d, k[d]), dat, msnap[d][k[d]]);
         chk($sformatf("d%0d_last_k%0d", d, k[d]), l, exp_last);
      end else begin
         chk($sformatf("d%0d_last_idle", d), l, 0);
      end
      if (v && rd) begin
         if (d == 0) got0.push_back(dat); else got1.push_back(dat);
      end
      if (v && first_v[d] < 0) first_v[d] = cyc - c0;
      if (dr) begin
         cnt_dr[d]++;
         if (first_dr[d] < 0) first_dr[d] = cyc - c0;
      end
      if (e) cnt_err[d]++;
      if (d == 0 && l) last_at0.push_back(cyc - c0);
      if (d == 0 && b) cnt_busy0++;
   endtask

   task automatic model_advance(input int d);
      logic cp, rd;
      int n;
      if (d == 0) begin cp = cap3; rd = rdy3; n = 3; end
      else        begin cp = cap1; rd = rdy1; n = 1; end
      if (reset) begin
         mode[d] = 0; k[d] = 0; err_m[d] = 0;
         return;
      end
      err_m[d] = cp && (mode[d] != 0);
      case (mode[d])
         0: if (cp) begin
               for (int i = 0; i < n; i++)
                  for (int j = 0; j < n; j++)
                     msnap[d][i*n+j] = (d == 0) ? res3[i][j] : res1[0][0];
               k[d] = 0;
               mode[d] = 1;
            end
         1: if (rd) begin
               k[d]++;
               if (k[d] == n * n) mode[d] = 2;
            end
         default: mode[d] = 0;
      endcase
   endtask

   // One clock: check at negedge, advance the model, then move past posedge.
   task automatic cycle();
      @(negedge clk);
      sample_check(0);
      sample_check(1);
      model_advance(0);
      model_advance(1);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic load3(input logic [31:0] base);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            res3[i][j] = base + 32'(i * 3 + j);
   endtask

   task automatic fill3(input logic [31:0] val);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            res3[i][j] = val;
   endtask

   // rmode: 0 ready always high, 1 pattern 1,0,0,..., 2 random
   task automatic run_idle(input int rmode, input int maxc);
      bit done;
      done = 0;
      for (int i = 0; i < maxc; i++) begin
         case (rmode)
            0:       begin rdy3 = 1'b1; rdy1 = 1'b1; end
            1:       begin rdy3 = (i % 3 == 0); rdy1 = rdy3; end
            default: begin rdy3 = 1'($urandom_range(0, 1)); rdy1 = 1'($urandom_range(0, 1)); end
         endcase
         cycle();
         if (mode[0] == 0 && mode[1] == 0) begin
            done = 1;
            break;
         end
      end
      if (!done) chk("timeout_idle", 0, 1);
   endtask

   task automatic expect_seq0(input string tag, input logic [31:0] base);
      chk({tag, "_count"}, got0.size(), 9);
      for (int i = 0; i < 9 && i < got0.size(); i++)
         chk($sformatf("%s_beat%0d", tag, i), got0[i], base + 32'(i));
   endtask

   initial begin
      logic [31:0] rexp3[9];
      logic [31:0] rexp1;
      bit seen;

      cyc = 0;
      for (int d = 0; d < 2; d++) begin mode[d] = 0; k[d] = 0; err_m[d] = 0; end
      reset = 1'b1;
      cap3 = 0; rdy3 = 0; cap1 = 0; rdy1 = 0;
      fill3(32'h0); res1[0][0] = 32'h0;
      clear_stats();
      cycle();
      cycle();
      chk("rst_valid", v3, 0);
      chk("rst_busy", b3, 0);
      reset = 1'b0;
      cycle();

      // Full-rate stream of 1..9, first capture after reset.
      load3(32'd1); rdy3 = 1;
      clear_stats();
      cap3 = 1; cycle(); cap3 = 0;
      run_idle(0, 20);
      expect_seq0("fullrate", 32'd1);
      chk("fullrate_first_beat_cyc", first_v[0], 1);
      chk("fullrate_drained_cyc", first_dr[0], 10);
      chk("fullrate_drained_cnt", cnt_dr[0], 1);
      chk("fullrate_busy_cycles", cnt_busy0, 10);
`ifdef DRAIN_ROW_LAST_EN
      chk("fullrate_last_cnt", last_at0.size(), 3);
      if (last_at0.size() == 3) begin
         chk("fullrate_last_a", last_at0[0], 3);
         chk("fullrate_last_b", last_at0[1], 6);
         chk("fullrate_last_c", last_at0[2], 9);
      end
`else
      chk("fullrate_last_cnt", last_at0.size(), 1);
      if (last_at0.size() == 1) chk("fullrate_last_a", last_at0[0], 9);
`endif

      // Backpressure: ready 1,0,0 repeating.
      load3(32'd1);
      clear_stats();
      cap3 = 1; cycle(); cap3 = 0;
      run_idle(1, 60);
      expect_seq0("stall", 32'd1);
      chk("stall_drained_cnt", cnt_dr[0], 1);

      // Capture during STREAM with changed inputs is rejected.
      load3(32'd1); rdy3 = 1;
      clear_stats();
      cap3 = 1; cycle(); cap3 = 0;
      repeat (3) cycle();
      fill3(32'hFF); cap3 = 1; cycle(); cap3 = 0;
      run_idle(0, 30);
      expect_seq0("midcap", 32'd1);
      chk("midcap_err_pulses", cnt_err[0], 1);

      // Asynchronous reset after beat 5, then a fresh capture.
      load3(32'd1); rdy3 = 1;
      clear_stats();
      cap3 = 1; cycle(); cap3 = 0;
      for (int i = 0; i < 20 && got0.size() < 5; i++) cycle();
      chk("rst5_beats_before", got0.size(), 5);
      clear_stats();
      #2 reset = 1'b1;
      #1;
      chk("rst5_async_valid", v3, 0);
      chk("rst5_async_busy", b3, 0);
      chk("rst5_async_drained", dr3, 0);
      for (int d = 0; d < 2; d++) begin mode[d] = 0; k[d] = 0; err_m[d] = 0; end
      cycle();
      cycle();
      reset = 1'b0;
      cycle();
      cycle();
      chk("rst5_no_drained", cnt_dr[0], 0);
      load3(32'd10);
      clear_stats();
      cap3 = 1; cycle(); cap3 = 0;
      run_idle(0, 20);
      expect_seq0("rst5_fresh", 32'd10);
      chk("rst5_fresh_first_cyc", first_v[0], 1);

      // M=1 single beat.
      res1[0][0] = 32'hDEADBEEF; rdy1 = 1;
      clear_stats();
      cap1 = 1; cycle(); cap1 = 0;
      run_idle(0, 10);
      chk("m1_count", got1.size(), 1);
      if (got1.size() == 1) chk("m1_data", got1[0], 32'hDEADBEEF);
      chk("m1_first_beat_cyc", first_v[1], 1);
      chk("m1_drained_cyc", first_dr[1], 2);

      // Capture in the DONE cycle is rejected; the next IDLE cycle accepts.
      load3(32'd1); rdy3 = 1;
      clear_stats();
      cap3 = 1; cycle(); cap3 = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (mode[0] == 2) begin seen = 1; break; end
         cycle();
      end
      chk("done_reached", seen, 1);
      chk("done_dut_drained", dr3, 1);
      fill3(32'hFF); cap3 = 1; cycle();
      load3(32'd10); cycle(); cap3 = 0;
      run_idle(0, 20);
      chk("donecap_err_pulses", cnt_err[0], 1);
      chk("donecap_count", got0.size(), 18);
      if (got0.size() == 18) begin
         chk("donecap_first2", got0[9], 32'd10);
         chk("donecap_last2", got0[17], 32'd18);
      end

      // Randomized data and ready on both instances.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
               res3[i][j] = $urandom;
               rexp3[i*3+j] = res3[i][j];
            end
         res1[0][0] = $urandom;
         rexp1 = res1[0][0];
         clear_stats();
         cap3 = 1; cap1 = 1; cycle(); cap3 = 0; cap1 = 0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
               res3[i][j] = $urandom;
            end
         res1[0][0] = $urandom;
         run_idle(2, 300);
         chk($sformatf("rand%0d_count3", r), got0.size(), 9);
         for (int i = 0; i < 9 && i < got0.size(); i++)
            chk($sformatf("rand%0d_beat%0d", r, i), got0[i], rexp3[i]);
         chk($sformatf("rand%0d_count1", r), got1.size(), 1);
         if (got1.size() == 1) chk($sformatf("rand%0d_m1", r), got1[0], rexp1);
         chk($sformatf("rand%0d_drained3", r), cnt_dr[0], 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
